mc_alu: RTL and testbench

- Multi-cycle ALU that consumes the 4-bit ALUop from the ALU-operation decoder, plus two register operands.
- Executes add/sub/and/or/xor/slt in a single registered cycle.
- Executes multiply iteratively into internal hi/lo registers, which are read back by the mflo/mfhi ops.
- Sits in the execute stage; the controller FSM issues `start` and waits for `done`.

---
 rtl/mc_alu.sv | 162 ++++++++++++++++
 tb/tb_mc_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with a single-cycle logic/arithmetic path and an
// iterative shift-add multiplier that writes internal hi/lo registers.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   operation request, accepted only while busy is low
//   alu_op  4-bit operation code
//   in0     operand A
//   in1     operand B
//   out     registered result (left unchanged by mult)
//   zero    registered flag, high when out is zero
//   busy    high while an operation is in flight
//   done    one-cycle pulse when out or hi/lo have been updated
//
// Build option: define MC_ALU_SIGNED_MULT_EN to make op 0101 a signed
// two's-complement multiply; by default it is unsigned.
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_MFLO = 4'b0110;
    localparam logic [3:0] OP_MFHI = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, FIN} state_t;

    state_t             state, state_nx;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a, b;
    logic [WIDTH-1:0]   hi, lo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] final_prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     psum;
    logic [WIDTH-1:0]   result;
    logic               accept;
    logic               last;

`ifdef MC_ALU_SIGNED_MULT_EN
    logic neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // The core multiplies magnitudes; the sign is restored when committing.
    assign final_prod = neg ? -prod : prod;
`else
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v;
    endfunction

    assign final_prod = prod;
`endif

    assign mcand = mag(a);

    // Upper half of the product register accumulates the multiplicand when
    // the current multiplier bit (prod[0]) is set; the carry lands in bit WIDTH.
    assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? mcand : '0};

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MFLO: result = lo;
            OP_MFHI: result = hi;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((alu_op == OP_MULT) ? MUL : EXEC) : IDLE;
            EXEC:    state_nx = IDLE;
            MUL:     state_nx = last ? FIN : MUL;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = state != IDLE;
        accept = state == IDLE && start;
        last   = cnt == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            zero <= 1'b1;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            op   <= '0;
            a    <= '0;
            b    <= '0;
            prod <= '0;
            cnt  <= '0;
`ifdef MC_ALU_SIGNED_MULT_EN
            neg  <= 1'b0;
`endif
        end else begin
            done <= state == EXEC || state == FIN;
            if (accept) begin
                op   <= alu_op;
                a    <= in0;
                b    <= in1;
                prod <= {{WIDTH{1'b0}}, mag(in1)};
                cnt  <= '0;
`ifdef MC_ALU_SIGNED_MULT_EN
                neg  <= in0[WIDTH-1] ^ in1[WIDTH-1];
`endif
            end
            if (state == EXEC) begin
                out  <= result;
                zero <= result == '0;
            end
            if (state == MUL) begin
                prod <= {psum, prod[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
            end
            if (state == FIN)
                {hi, lo} <= final_prod;
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed and randomized checks of mc_alu against a latency and
// arithmetic model of the operation set.
module tb_mc_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] out;
    logic         zero;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .alu_op(alu_op),
        .in0(in0),
        .in1(in1),
        .out(out),
        .zero(zero),
        .busy(busy),
        .done(done)
    );

    int n_pass = 0;
    int n_tot = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: an accepted op retires after a fixed latency (1, or W+1 for mult)
    // and its effect is computed with plain arithmetic at retirement.
    int           m_rem = 0;
    logic [3:0]   m_op = 4'd0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W-1:0] m_out = '0, m_hi = '0, m_lo = '0;
    logic         m_zero = 1'b1;
    logic         m_done = 1'b0;
    logic [63:0]  m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_out = '0; m_zero = 1'b1; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    if (m_op == 4'd5) begin
`ifdef MC_ALU_SIGNED_MULT_EN
                        m_p = 64'($signed(m_a)) * 64'($signed(m_b));
`else
                        m_p = {32'b0, m_a} * {32'b0, m_b};
`endif
                        m_hi = m_p[63:32];
                        m_lo = m_p[31:0];
                    end else begin
                        case (m_op)
                            4'd0: m_out = m_a + m_b;
                            4'd1: m_out = m_a - m_b;
                            4'd2: m_out = m_a & m_b;
                            4'd3: m_out = m_a | m_b;
                            4'd4: m_out = m_a ^ m_b;
                            4'd6: m_out = m_lo;
                            4'd7: m_out = m_hi;
                            4'd8: m_out = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0;
                            default: m_out = '0;
                        endcase
                        m_zero = m_out == '0;
                    end
                end
            end else if (start) begin
                m_op = alu_op; m_a = in0; m_b = in1;
                m_rem = (alu_op == 4'd5) ? W + 1 : 1;
            end
        end
    end

    logic sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en) begin
            chk("sb_busy", 32'(busy), 32'(m_rem > 0));
            chk("sb_done", 32'(done), 32'(m_done));
            chk("sb_out", out, m_out);
            chk("sb_zero", 32'(zero), 32'(m_zero));
            if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
        end
    end

    task automatic go(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        alu_op = op; in0 = x; in1 = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_op = 4'($urandom);
        in0 = $urandom;
        in1 = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done) return;
            if (busy) n++;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out", out, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);

        go(4'd0, 32'd7, 32'd5); wait_done(n);
        chk("add_out", out, 32'd12);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_busy_cycles", 32'(n), 32'd1);
        go(4'd1, 32'd5, 32'd5); wait_done(n);
        chk("sub_out", out, 32'd0);
        chk("sub_zero", 32'(zero), 32'd1);
        go(4'd8, 32'hFFFF_FFFF, 32'd1); wait_done(n);
        chk("slt_neg_lt", out, 32'd1);
        go(4'd8, 32'd1, 32'hFFFF_FFFF); wait_done(n);
        chk("slt_pos_ge", out, 32'd0);

        go(4'd0, 32'd7, 32'd5); wait_done(n);
        go(4'd5, 32'h0001_0000, 32'h0003_0000); wait_done(n);
        chk("mult_busy_cycles", 32'(n), 32'd33);
        chk("mult_out_keep", out, 32'd12);
        go(4'd6, 32'd0, 32'd0); wait_done(n);
        chk("mflo_big", out, 32'd0);
        go(4'd7, 32'd0, 32'd0); wait_done(n);
        chk("mfhi_big", out, 32'd3);
        go(4'd11, 32'd9, 32'd9); wait_done(n);
        chk("reserved_out", out, 32'd0);
        chk("reserved_zero", 32'(zero), 32'd1);

        go(4'd5, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        alu_op = 4'd0; in0 = 32'd1; in1 = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        go(4'd6, 32'd0, 32'd0); wait_done(n);
        chk("ignored_start_mflo", out, 32'd12);

        go(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out", out, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        go(4'd7, 32'd0, 32'd0); wait_done(n);
        chk("midrst_mfhi", out, 32'd0);
        go(4'd6, 32'd0, 32'd0); wait_done(n);
        chk("midrst_mflo", out, 32'd0);

        go(4'd5, 32'hFFFF_FFFE, 32'd3); wait_done(n);
        go(4'd6, 32'd0, 32'd0); wait_done(n);
        chk("neg_mult_lo", out, 32'hFFFF_FFFA);
        go(4'd7, 32'd0, 32'd0); wait_done(n);
`ifdef MC_ALU_SIGNED_MULT_EN
        chk("neg_mult_hi", out, 32'hFFFF_FFFF);
`else
        chk("neg_mult_hi", out, 32'h0000_0002);
`endif

        for (int c = 0; c < 3000; c++) begin
            start = $urandom_range(0, 2) == 0;
            alu_op = 4'($urandom_range(0, 15));
            in0 = pick();
            in1 = pick();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int i = 0; i < 64 && (busy || done); i++) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
